// File: rtl/adder_seq_nbit_pkg.sv
// Shared types and default sizing for the slice-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

endpackage

// File: rtl/adder_seq_nbit_if.sv
// Operand/result bundle between the controller and the slice-serial adder.
interface adder_seq_nbit_if #(
    parameter int WIDTH = adder_pkg::DEF_WIDTH
);
    // start is sampled only while the adder is idle; busy marks a running
    // operation, and done pulses for one cycle when sum/c_out/overflow become
    // valid. The results then stay put until the next accepted start.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/adder_seq_nbit_slice.sv
// One SLICE-bit ripple step; the top reuses a single instance every cycle.
module adder_slice #(
    parameter int SLICE = adder_pkg::DEF_SLICE
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    logic [SLICE:0] total;

    assign total = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, ci};
    assign s     = total[SLICE-1:0];
    assign co    = total[SLICE];
endmodule

// File: rtl/adder_seq_nbit.sv
// WIDTH-bit add/subtract evaluated one SLICE per clock, LSB slice first,
// with the inter-slice carry held in a register.
module adder_seq_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_seq_nbit_if.slave         bus,
    output state_t                  state_dbg
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             carry_r, c_out_r, ovf_r;
    logic [IW-1:0]    idx;
    logic             last;
    logic [SLICE-1:0] a_s, b_s, s_s;
    logic             co_s;

    assign last = (idx == IW'(NSLICE - 1));
    assign a_s  = a_r[int'(idx)*SLICE +: SLICE];
    assign b_s  = b_r[int'(idx)*SLICE +: SLICE];

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a_s (a_s),
        .b_s (b_s),
        .ci  (carry_r),
        .s   (s_s),
        .co  (co_s)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is folded into operand capture: b is inverted and the
    // carry forced to 1, so the RUN path only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub | bus.c_in;
                        idx     <= '0;
                        sum_r   <= '0;
                        c_out_r <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                RUN: begin
                    sum_r[int'(idx)*SLICE +: SLICE] <= s_s;
                    carry_r <= co_s;
                    idx     <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        c_out_r <= co_s;
                        ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                   (s_s[SLICE-1] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_r;
    assign bus.c_out    = c_out_r;
    assign bus.overflow = ovf_r;
    assign state_dbg    = state;
endmodule

// File: tb/tb_adder_seq_nbit.sv
// Directed and reference-model checks of the slice-serial adder at three sizes.
module tb_adder_seq_nbit;
    import adder_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_seq_nbit_if #(.WIDTH(16)) bus16 ();
    adder_seq_nbit_if #(.WIDTH(8))  bus8  ();
    adder_seq_nbit_if #(.WIDTH(32)) bus32 ();
    state_t st16, st8, st32;

    adder_seq_nbit #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16), .state_dbg(st16));
    adder_seq_nbit #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8),  .state_dbg(st8));
    adder_seq_nbit #(.WIDTH(32), .SLICE(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32), .state_dbg(st32));

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drivers
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo, input bit repulse);
        int busy_cnt = 0;
        int edges = 0;
        bit seen = 0;
        bus16.a = a; bus16.b = b; bus16.c_in = cin; bus16.sub = sub; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            if (bus16.busy) busy_cnt++;
            if (repulse && k == 1) begin
                bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.sub = ~sub;
            end
            if (repulse && k == 3) bus16.start = 1'b0;
            step();
            edges = k;
            if (bus16.done) seen = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'd4);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
        check({tag, "_busy_at_done"}, 64'(bus16.busy), 64'd0);
        check({tag, "_sum"}, 64'(bus16.sum), 64'(es));
        check({tag, "_c_out"}, 64'(bus16.c_out), 64'(ec));
        check({tag, "_ovf"}, 64'(bus16.overflow), 64'(eo));
        step();
        check({tag, "_done_pulse"}, 64'(bus16.done), 64'd0);
        check({tag, "_sum_held"}, 64'(bus16.sum), 64'(es));
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        logic [31:0] be;
        logic [32:0] tot;
        logic [33:0] exp;
        bit seen = 0;
        be  = sub ? ~b : b;
        tot = {1'b0, a} + {1'b0, be} + {32'd0, (sub | cin)};
        exp_q.push_back({(a[31] == be[31]) && (tot[31] != a[31]), tot});
        bus32.a = a; bus32.b = b; bus32.c_in = cin; bus32.sub = sub; bus32.start = 1'b1;
        step();
        bus32.start = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (bus32.done) seen = 1;
        end
        check("r32_done_seen", 64'(seen), 64'd1);
        exp = exp_q.pop_front();
        check("r32_sum", 64'(bus32.sum), 64'(exp[31:0]));
        check("r32_c_out", 64'(bus32.c_out), 64'(exp[32]));
        check("r32_ovf", 64'(bus32.overflow), 64'(exp[33]));
        step();
    endtask

    initial begin
        bit got_done;
        int edges;
        bus16.start = 0; bus16.a = 0; bus16.b = 0; bus16.c_in = 0; bus16.sub = 0;
        bus8.start  = 0; bus8.a  = 0; bus8.b  = 0; bus8.c_in  = 0; bus8.sub  = 0;
        bus32.start = 0; bus32.a = 0; bus32.b = 0; bus32.c_in = 0; bus32.sub = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", 64'(bus16.busy), 64'd0);
        check("rst_done", 64'(bus16.done), 64'd0);
        check("rst_sum", 64'(bus16.sum), 64'd0);
        check("rst_c_out", 64'(bus16.c_out), 64'd0);
        check("rst_ovf", 64'(bus16.overflow), 64'd0);

        run16("add_basic", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
        run16("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run16("s_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run16("c_in",      16'h0002, 16'h0002, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 0);
        run16("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        run16("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        run16("sub_cin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0, 0);
        run16("repulse",   16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1);

        // reset landing in the second RUN cycle
        bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.c_in = 0; bus16.sub = 0; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(bus16.busy), 64'd0);
        check("midrst_sum", 64'(bus16.sum), 64'd0);
        check("midrst_done", 64'(bus16.done), 64'd0);
        check("midrst_c_out", 64'(bus16.c_out), 64'd0);
        got_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus16.done) got_done = 1;
            step();
        end
        check("midrst_no_done", 64'(got_done), 64'd0);
        run16("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

        // single-slice instance
        bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c_in = 0; bus8.sub = 0; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        check("w8_busy", 64'(bus8.busy), 64'd1);
        edges = 0;
        got_done = 0;
        for (int k = 1; k <= 8 && !got_done; k++) begin
            step();
            edges = k;
            if (bus8.done) got_done = 1;
        end
        check("w8_done_seen", 64'(got_done), 64'd1);
        check("w8_latency", 64'(edges), 64'd1);
        check("w8_sum", 64'(bus8.sum), 64'h00);
        check("w8_c_out", 64'(bus8.c_out), 64'd1);
        check("w8_ovf", 64'(bus8.overflow), 64'd0);
        step();

        // 32-bit random against the reference model
        for (int i = 0; i < 1000; i++) begin
            run32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_seq_nbit.md
# adder_seq_nbit

Parametrised multi-cycle adder/subtractor for the controller datapath. It generalises the fixed 4-bit ripple adder to WIDTH-bit operands. Operands are processed in SLICE-bit chunks, one chunk per clock, with the carry registered between chunks. It adds a subtract mode, a signed-overflow flag and a start/busy/done handshake, so wide arithmetic fits the controller's timing without a long combinational carry chain.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 1.
- SLICE, 4: bits processed per cycle; must divide WIDTH exactly. NSLICE = WIDTH/SLICE.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in for add mode; ignored when sub=1.
- sub  in  1  0: a+b+c_in; 1: a−b, computed as a+~b+1.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result, held until the next accepted start.
- c_out  out  1  carry out of bit WIDTH−1. In sub mode, 1 means no borrow.
- overflow  out  1  signed overflow of the operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - On that edge, latch a, b_eff (b, or ~b when sub=1), the carry (c_in, or 1 when sub=1) and sub.
  - Also clear sum, c_out and overflow, and set slice index idx=0.
- RUN: each edge adds slice idx of a_r and b_eff_r plus the registered carry.
  - Write the result into sum[idx*SLICE +: SLICE], store the carry, and increment idx.
  - After the edge that writes slice NSLICE−1, go to DONE.
  - On that same edge, latch c_out (final carry) and overflow = (a_r[MSB] == b_eff_r[MSB]) && (sum[MSB] != a_r[MSB]).
- DONE: done=1 for exactly one cycle, then IDLE.
- Width rules:
  - All slice arithmetic is SLICE+1 bits wide; the top bit is the carry.
  - idx width is max(1, $clog2(NSLICE)).
  - Wrap-around is modulo 2^WIDTH; e.g. 0xFFFF+1 gives 0x0000 with c_out=1.
- start while in RUN or DONE is ignored; it is not queued.
- Operand or mode changes after the accepting edge have no effect.
- rst=1 at any edge, including mid-operation:
  - state=IDLE, idx=0, stored carry=0.
  - sum=0, c_out=0, overflow=0, busy=0, done=0.
  - Any partial result is discarded.
- If rst and start are both high on the same edge, reset wins.

## Timing
- Edge E0: start accepted in IDLE.
- Edges E1..E_NSLICE: slices 0..NSLICE−1 are written, LSB slice first.
- busy=1 from after E0 until after E_NSLICE; that is NSLICE cycles.
- done=1 in the cycle after E_NSLICE. From then on, sum, c_out and overflow are valid and stable.
- Latency from start sampled to done high is NSLICE+1 cycles. With the defaults, done is seen 5 cycles after start.
- The earliest next start is accepted at E_NSLICE+2, one cycle after done. Throughput is one operation per NSLICE+2 cycles.
- busy and done are registered outputs; no output depends combinationally on inputs.
- Reset values: busy=0, done=0, sum=0, c_out=0, overflow=0.

## Structure
- Package adder_pkg holds:
  - the FSM state typedef enum logic [1:0] {IDLE, RUN, DONE};
  - the default WIDTH and SLICE constants.
- Sub-module adder_slice is purely combinational and parametrised by SLICE.
  - Ports: a_s[SLICE], b_s[SLICE], ci → s[SLICE], co.
  - It is instantiated once and muxed by idx.
- The top level contains the FSM, the operand, carry and idx registers, and the result and flag registers.

## Test plan
- WIDTH=16, SLICE=4, add mode:
  - 0x0000 + 0x0001, c_in=0 → sum=0x0001, c_out=0, overflow=0.
  - done is high exactly 5 cycles after start, and busy is high for the 4 cycles before it.
- Wrap-around: 0xFFFF + 0x0001 → sum=0x0000, c_out=1, overflow=0.
- Signed overflow: 0x7FFF + 0x0001 → 0x8000 with overflow=1.
- Carry-in: 0x0002 + 0x0002 with c_in=1 → 0x0005.
- Subtract mode:
  - 0x0005 − 0x0007 → sum=0xFFFE, c_out=0, overflow=0.
  - 0x8000 − 0x0001 → 0x7FFF with overflow=1.
- Handshake and reset:
  - start re-pulsed with new operands while busy → ignored; the original result is delivered.
  - rst during the 2nd RUN cycle → the next cycle shows busy=0 and sum=0, and no done pulse occurs.
  - A following start completes correctly.
- Parameter sweep:
  - WIDTH=8, SLICE=8 (NSLICE=1): 0xFF + 0x01 → 0x00 with c_out=1, and done 2 cycles after start.
  - WIDTH=32, SLICE=4: random operands checked against a reference model for ≥1000 operations.
